// File: rtl/rpm_window_ctrl.sv
// rpm_window_ctrl: crank-tooth period measurement feeding a moving-sum
// window, with stall detection and window flush control.
module rpm_window_ctrl #(
  parameter int LENGTH_INPUT = 16,
  parameter int LENGTH_SUM   = 32,
  parameter int COUNT_SUMS   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tooth_in,
  input  logic                    flush_req,
  input  logic [LENGTH_SUM-1:0]   sum_in,
  output logic [LENGTH_INPUT-1:0] sample_out,
  output logic                    shift_en,
  output logic [LENGTH_SUM-1:0]   rpm_sum,
  output logic                    sum_valid,
  output logic                    stalled
);

  localparam int FW = $clog2(COUNT_SUMS + 1);
  localparam logic [FW-1:0] FULL = FW'(COUNT_SUMS);
  localparam logic [LENGTH_INPUT-1:0] MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    FLUSH
  } state_t;

  state_t                  state_q, state_d;
  logic                    s1_q, s2_q, hist_q;
  logic [LENGTH_INPUT-1:0] cnt_q, cnt_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic [FW-1:0]           fill_q, fill_d;
  logic [LENGTH_INPUT-1:0] sample_q, sample_d;
  logic                    shift_q, shift_d;
  logic [LENGTH_SUM-1:0]   rpm_q, rpm_d;
  logic                    valid_q, valid_d;
  logic                    stalled_q, stalled_d;
  logic                    tooth_evt;
  logic                    go_flush;

  assign tooth_evt  = s2_q & ~hist_q;
  assign sample_out = sample_q;
  assign shift_en   = shift_q;
  assign rpm_sum    = rpm_q;
  assign sum_valid  = valid_q;
  assign stalled    = stalled_q;

  // Synchronize the raw tooth input and keep one cycle of history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      s1_q   <= tooth_in;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      fcnt_q    <= '0;
      fill_q    <= '0;
      sample_q  <= '0;
      shift_q   <= 1'b0;
      rpm_q     <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      fill_q    <= fill_d;
      sample_q  <= sample_d;
      shift_q   <= shift_d;
      rpm_q     <= rpm_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
    end
  end

  // Next-state: period measurement, flush sequencing, window capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;
    fill_d    = fill_q;
    sample_d  = sample_q;
    shift_d   = 1'b0;
    rpm_d     = rpm_q;
    valid_d   = valid_q;
    stalled_d = stalled_q;
    go_flush  = 1'b0;

    // Sum reflects the shift issued last cycle once the window is full
    if (shift_q && fill_q == FULL) begin
      rpm_d   = sum_in;
      valid_d = 1'b1;
    end

    if (flush_req) begin
      go_flush = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (tooth_evt) begin
            state_d   = MEASURE;
            cnt_d     = LENGTH_INPUT'(1);
            stalled_d = 1'b0;
          end
        end
        MEASURE: begin
          if (tooth_evt) begin
            sample_d = cnt_q;
            cnt_d    = LENGTH_INPUT'(1);
            shift_d  = 1'b1;
            if (fill_q != FULL) fill_d = fill_q + FW'(1);
          end else if (cnt_q == MAX) begin
            go_flush  = 1'b1;
            stalled_d = 1'b1;
          end else begin
            cnt_d = cnt_q + LENGTH_INPUT'(1);
          end
        end
        FLUSH: begin
          if (fcnt_q == FULL) begin
            state_d = IDLE;
          end else begin
            fcnt_d   = fcnt_q + FW'(1);
            shift_d  = 1'b1;
            sample_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Flush entry issues the first zero shift so every pulse lands in FLUSH
    if (go_flush) begin
      state_d  = FLUSH;
      fcnt_d   = FW'(1);
      shift_d  = 1'b1;
      sample_d = '0;
      cnt_d    = '0;
      fill_d   = '0;
      valid_d  = 1'b0;
      rpm_d    = '0;
    end
  end

endmodule

// File: doc/rpm_window_ctrl.md
RPM_WINDOW_CTRL -- requirements
Module: rpm_window_ctrl

Interface
REQ-001 SHALL have parameter LENGTH_INPUT, default 16, width of one tooth-period sample.
REQ-002 SHALL have parameter LENGTH_SUM, default 32, width of the window sum.
REQ-003 SHALL have parameter COUNT_SUMS, default 32, depth of the moving-sum window; the number of shift pulses after which sum_in is valid.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port tooth_in  input  1  raw asynchronous crank-tooth signal.
REQ-007 SHALL have port flush_req  input  1  synchronous one-cycle request to clear the window.
REQ-008 SHALL have port sum_in  input  LENGTH_SUM  window sum returned by the moving-sum shift register.
REQ-009 SHALL have port sample_out  output  LENGTH_INPUT  period sample driven to the shift register.
REQ-010 SHALL have port shift_en  output  1  one-cycle shift strobe to the shift register.
REQ-011 SHALL have port rpm_sum  output  LENGTH_SUM  last valid window sum, registered.
REQ-012 SHALL have port sum_valid  output  1  rpm_sum reflects a full window.
REQ-013 SHALL have port stalled  output  1  engine-stopped indication.

Function
REQ-014 SHALL pass tooth_in through a 2-flop synchronizer plus one history flop; tooth event = synchronized high AND history low, one cycle wide.
REQ-015 SHALL implement states IDLE, MEASURE, FLUSH.
REQ-016 IDLE: period counter held at 0; on tooth event -> MEASURE, counter <= 1, no sample emitted, stalled <= 0.
REQ-017 MEASURE: counter increments by 1 per cycle, saturating at 2^LENGTH_INPUT-1 (MAX).
REQ-018 MEASURE, tooth event: sample_out <= counter, counter <= 1, shift_en = 1 in the next cycle only; sample_out equals cycles between consecutive events.
REQ-019 MEASURE, counter == MAX with no event: -> FLUSH, stalled <= 1.
REQ-020 MEASURE, counter == MAX coinciding with an event: event wins; sample MAX emitted, no flush.
REQ-021 FLUSH: sample_out = 0, shift_en = 1 for exactly COUNT_SUMS consecutive cycles, then -> IDLE; tooth events ignored.
REQ-022 On FLUSH entry: fill counter <= 0, sum_valid <= 0, rpm_sum <= 0.
REQ-023 flush_req in any state -> FLUSH next cycle, restarting the flush count if already in FLUSH; stalled unchanged.
REQ-024 flush_req coinciding with a tooth event: flush wins, sample discarded, no shift_en.
REQ-025 Fill counter counts MEASURE shift pulses, saturating at COUNT_SUMS; FLUSH pulses not counted.
REQ-026 When fill == COUNT_SUMS, sum_in SHALL be captured into rpm_sum one cycle after each shift_en; sum_valid <= 1 on the first such capture.
REQ-027 rpm_sum and sum_valid SHALL hold between captures; shift_en never asserted in IDLE.
REQ-028 Latency: tooth_in rise -> event 2-3 cycles; event -> shift_en +1; shift_en -> rpm_sum update +1.

Reset
REQ-029 reset SHALL asynchronously force state IDLE; counter, fill, sync flops, sample_out, shift_en, rpm_sum, sum_valid, stalled to 0.
REQ-030 Reset asserted mid-FLUSH or mid-MEASURE SHALL abort with no further shift_en pulses; after release, the first tooth event is treated as in IDLE.

Verification (LENGTH_INPUT=8, COUNT_SUMS=4)
REQ-031 Teeth every 10 cycles, 6 edges -> first edge no shift; 5 shift_en pulses each with sample_out=10; sum_valid rises after 4th pulse; rpm_sum = sum_in value.
REQ-032 Tooth then none for 255+ cycles -> stalled=1 when counter hits 255; 4 shift_en pulses with sample_out=0; sum_valid=0, rpm_sum=0; state IDLE.
REQ-033 Next edge after stall -> stalled=0, no shift; following edge 20 cycles later -> sample_out=20.
REQ-034 flush_req in same cycle as tooth event in MEASURE -> no sample shift; 4 zero shifts; stalled stays 0.
REQ-035 Event exactly when counter==255 -> sample_out=255, shift_en pulse, no flush, stalled=0.
REQ-036 reset asserted during 2nd flush cycle -> all outputs 0 immediately; no further shift_en.
